// File: rtl/btn_debouncer_if.sv
// Button bundle between the raw pins and the debouncer: raw levels in, conditioned level/press/release out.
// The master side drives the pins and the slave side is the debouncer.
interface btn_debouncer_if #(
    parameter int NB_BTN = 3
);
    logic [NB_BTN-1:0] i_btn;
    logic [NB_BTN-1:0] o_btn_level;
    logic [NB_BTN-1:0] o_btn_pulse;
    logic [NB_BTN-1:0] o_btn_release;

    modport master (
        output i_btn,
        input  o_btn_level,
        input  o_btn_pulse,
        input  o_btn_release
    );

    modport slave (
        input  i_btn,
        output o_btn_level,
        output o_btn_pulse,
        output o_btn_release
    );
endinterface

// File: rtl/btn_debouncer.sv
// Per-channel 2-FF synchroniser plus a bounce-rejecting FSM; level/press/release all settle COUNT_MAX+3 edges after a pin change.
// Free-running with no backpressure: each accepted press loads downstream exactly once.
module btn_debouncer #(
    parameter int NB_BTN    = 3,
    parameter int COUNT_MAX = 1_000_000,
    parameter int NB_CNT    = 20
) (
    input  logic           i_clk,
    input  logic           i_reset,
    btn_debouncer_if.slave btn_if
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(COUNT_MAX - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    logic [NB_BTN-1:0] sync1_q, sync1_d;
    logic [NB_BTN-1:0] sync2_q, sync2_d;
    state_e            state_q [NB_BTN];
    state_e            state_d [NB_BTN];
    logic [NB_CNT-1:0] cnt_q   [NB_BTN];
    logic [NB_CNT-1:0] cnt_d   [NB_BTN];
    logic [NB_BTN-1:0] level_q, level_d;
    logic [NB_BTN-1:0] pulse_q, pulse_d;
    logic [NB_BTN-1:0] release_q, release_d;

    always_comb begin
        sync1_d   = btn_if.i_btn;
        sync2_d   = sync1_q;
        level_d   = '0;
        pulse_d   = '0;
        release_d = '0;
        for (int i = 0; i < NB_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = WAIT_HIGH;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = WAIT_LOW;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = IDLE_LOW;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
            // Level follows the next state so it moves on the same edge as the pulse.
            level_d[i] = (state_d[i] == HIGH) || (state_d[i] == WAIT_LOW);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            pulse_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NB_BTN; i++) begin
                state_q[i] <= IDLE_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
            for (int i = 0; i < NB_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_if.o_btn_level   = level_q;
    assign btn_if.o_btn_pulse   = pulse_q;
    assign btn_if.o_btn_release = release_q;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with COUNT_MAX=4, so every accepted edge appears 7 clock edges after the pin moves.
module tb_btn_debouncer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    btn_debouncer_if #(.NB_BTN(3)) bif ();

    btn_debouncer #(
        .NB_BTN   (3),
        .COUNT_MAX(4),
        .NB_CNT   (3)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .btn_if (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bif.i_btn = 3'b000;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bif.i_btn = 3'b111;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (bif.o_btn_level !== 3'b000) begin
            errors++; $display("FAIL reset_level: got %b want 000", bif.o_btn_level);
        end
        checks++;
        if (bif.o_btn_pulse !== 3'b000) begin
            errors++; $display("FAIL reset_pulse: got %b want 000", bif.o_btn_pulse);
        end
        checks++;
        if (bif.o_btn_release !== 3'b000) begin
            errors++; $display("FAIL reset_release: got %b want 000", bif.o_btn_release);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                checks++;
                if (bif.o_btn_pulse !== 3'b000 || bif.o_btn_level !== 3'b000) begin
                    errors++; $display("FAIL reset_early: pulse %b level %b want 000/000", bif.o_btn_pulse, bif.o_btn_level);
                end
            end else if (k == 7) begin
                checks++;
                if (bif.o_btn_pulse !== 3'b111 || bif.o_btn_level !== 3'b111) begin
                    errors++; $display("FAIL reset_press: pulse %b level %b want 111/111", bif.o_btn_pulse, bif.o_btn_level);
                end
            end else if (k == 8) begin
                checks++;
                if (bif.o_btn_pulse !== 3'b000 || bif.o_btn_level !== 3'b111) begin
                    errors++; $display("FAIL reset_after: pulse %b level %b want 000/111", bif.o_btn_pulse, bif.o_btn_level);
                end
            end
        end
    endtask

    task automatic test_press_release();
        int pulse_cnt, pulse_at, rel_cnt, rel_at, other_bad;
        pulse_cnt = 0; pulse_at = 0; rel_cnt = 0; rel_at = 0; other_bad = 0;
        do_reset();
        bif.i_btn = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bif.o_btn_pulse[0]) begin pulse_cnt++; pulse_at = k; end
            if (k == 7 && bif.o_btn_level[0] !== 1'b1) other_bad++;
            if (k == 6 && bif.o_btn_level[0] !== 1'b0) other_bad++;
            if ((bif.o_btn_pulse[2:1] | bif.o_btn_level[2:1] | bif.o_btn_release) !== 3'b000) other_bad++;
        end
        checks++;
        if (pulse_cnt !== 1 || pulse_at !== 7) begin
            errors++; $display("FAIL press_pulse: count %0d at edge %0d want 1 at 7", pulse_cnt, pulse_at);
        end
        bif.i_btn = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bif.o_btn_release[0]) begin rel_cnt++; rel_at = k; end
            if (k == 6 && bif.o_btn_level[0] !== 1'b1) other_bad++;
            if (k == 7 && bif.o_btn_level[0] !== 1'b0) other_bad++;
            if ((bif.o_btn_pulse | bif.o_btn_level[2:1] | bif.o_btn_release[2:1]) !== 3'b000) other_bad++;
        end
        checks++;
        if (rel_cnt !== 1 || rel_at !== 7) begin
            errors++; $display("FAIL release_pulse: count %0d at edge %0d want 1 at 7", rel_cnt, rel_at);
        end
        checks++;
        if (other_bad !== 0) begin
            errors++; $display("FAIL press_side_effects: %0d bad samples want 0", other_bad);
        end
    endtask

    task automatic test_bounce();
        int toggle_pulses, pulse_cnt, pulse_at;
        toggle_pulses = 0; pulse_cnt = 0; pulse_at = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            bif.i_btn = ((k % 4) < 2) ? 3'b010 : 3'b000;
            tick();
            if (bif.o_btn_pulse !== 3'b000 || bif.o_btn_level !== 3'b000) toggle_pulses++;
        end
        checks++;
        if (toggle_pulses !== 0) begin
            errors++; $display("FAIL bounce_absorbed: %0d active samples want 0", toggle_pulses);
        end
        bif.i_btn = 3'b010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bif.o_btn_pulse[1]) begin pulse_cnt++; pulse_at = k; end
        end
        checks++;
        if (pulse_cnt !== 1 || pulse_at !== 7) begin
            errors++; $display("FAIL bounce_settle: count %0d at edge %0d want 1 at 7", pulse_cnt, pulse_at);
        end
    endtask

    task automatic test_glitch();
        int active;
        active = 0;
        do_reset();
        bif.i_btn = 3'b100;
        for (int k = 0; k < 4; k++) begin
            tick();
            if ((bif.o_btn_level[2] | bif.o_btn_pulse[2] | bif.o_btn_release[2]) !== 1'b0) active++;
        end
        bif.i_btn = 3'b000;
        for (int k = 0; k < 20; k++) begin
            tick();
            if ((bif.o_btn_level[2] | bif.o_btn_pulse[2] | bif.o_btn_release[2]) !== 1'b0) active++;
        end
        checks++;
        if (active !== 0) begin
            errors++; $display("FAIL glitch_rejected: %0d active samples want 0", active);
        end
    endtask

    task automatic test_reset_mid_count();
        int pulse_cnt, pulse_at, active;
        pulse_cnt = 0; pulse_at = 0; active = 0;
        do_reset();
        bif.i_btn = 3'b001;
        for (int k = 0; k < 4; k++) tick();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ((bif.o_btn_level | bif.o_btn_pulse | bif.o_btn_release) !== 3'b000) begin
            errors++; $display("FAIL midreset_outputs: level %b pulse %b want 000", bif.o_btn_level, bif.o_btn_pulse);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (bif.o_btn_pulse[0]) begin pulse_cnt++; pulse_at = k; end
        end
        checks++;
        if (pulse_cnt !== 1 || pulse_at !== 7) begin
            errors++; $display("FAIL midreset_pulse: count %0d at edge %0d want 1 at 7", pulse_cnt, pulse_at);
        end
        checks++;
        if (bif.o_btn_level !== 3'b001) begin
            errors++; $display("FAIL held_level: got %b want 001", bif.o_btn_level);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bif.o_btn_level !== 3'b000) begin
            errors++; $display("FAIL async_clear: level %b want 000", bif.o_btn_level);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bif.i_btn = 3'b111;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 7) begin
                checks++;
                if (bif.o_btn_pulse !== 3'b111) begin
                    errors++; $display("FAIL parallel_pulse: got %b want 111", bif.o_btn_pulse);
                end
            end else if (k == 8) begin
                checks++;
                if (bif.o_btn_pulse !== 3'b000 || bif.o_btn_level !== 3'b111) begin
                    errors++; $display("FAIL parallel_after: pulse %b level %b want 000/111", bif.o_btn_pulse, bif.o_btn_level);
                end
            end
        end
        // Release, then re-press immediately after the release is accepted.
        bif.i_btn = 3'b000;
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (bif.o_btn_release !== 3'b111 || bif.o_btn_level !== 3'b000) begin
            errors++; $display("FAIL parallel_release: release %b level %b want 111/000", bif.o_btn_release, bif.o_btn_level);
        end
        bif.i_btn = 3'b101;
        for (int k = 0; k < 7; k++) tick();
        checks++;
        if (bif.o_btn_pulse !== 3'b101) begin
            errors++; $display("FAIL repress_pulse: got %b want 101", bif.o_btn_pulse);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        bif.i_btn = 3'b000;
        test_reset();
        test_press_release();
        test_bounce();
        test_glitch();
        test_reset_mid_count();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
# btn_debouncer

Multi-channel push-button conditioner that sits directly upstream of the ALU register-loading logic. For each raw board button it synchronises the input into the `i_clk` domain and rejects contact bounce. It outputs a stable debounced level and a one-cycle press pulse, and the press pulse drives the operand/opcode load enables (`i_btn`) of the downstream stage. This ensures one physical press loads a register exactly once.

## Interface
- `NB_BTN`, 3, number of independent button channels.
- `COUNT_MAX`, 1_000_000, extra stable sampled cycles required after the first stable sample before a level is accepted (10 ms at 100 MHz). Must be ≥ 1.
- `NB_CNT`, 20, debounce counter width. Must satisfy 2^NB_CNT > COUNT_MAX − 1.
- `i_clk`, input, 1, single system clock; all logic is rising-edge.
- `i_reset`, input, 1, asynchronous, active-high reset.
- `i_btn`, input, NB_BTN, raw asynchronous button pins, active-high.
- `o_btn_level`, output, NB_BTN, debounced button level, registered.
- `o_btn_pulse`, output, NB_BTN, one-cycle high on each accepted press (rising edge of `o_btn_level`), registered.
- `o_btn_release`, output, NB_BTN, one-cycle high on each accepted release (falling edge of `o_btn_level`), registered.

## Operation
- The design uses one clock and an asynchronous, active-high reset. `i_reset` clears all flops immediately, without waiting for a clock edge.
- Each channel is fully independent: a 2-FF synchronizer, an NB_CNT-bit counter, a 4-state FSM and three output flops. `sync` denotes the output of the second synchronizer flop.
- FSM states and transitions, evaluated at each rising edge:
  - `IDLE_LOW`:
    - `sync`=1 → `WAIT_HIGH`, counter cleared to 0.
    - Otherwise stay.
  - `WAIT_HIGH`:
    - `sync`=0 → `IDLE_LOW`, counter cleared.
    - `sync`=1 with counter = COUNT_MAX−1 → `HIGH`.
    - `sync`=1 otherwise → counter +1.
  - `HIGH`:
    - `sync`=0 → `WAIT_LOW`, counter cleared to 0.
    - Otherwise stay.
  - `WAIT_LOW`:
    - `sync`=1 → `HIGH`, counter cleared.
    - `sync`=0 with counter = COUNT_MAX−1 → `IDLE_LOW`.
    - `sync`=0 otherwise → counter +1.
- The counter never wraps; it is only compared against COUNT_MAX−1 and is cleared on every state change.
- Outputs are registered and derived from the next state, so they change on the same edge as the state:
  - `o_btn_level` = 1 in `HIGH` or `WAIT_LOW`, otherwise 0.
  - `o_btn_pulse` = 1 for exactly the one cycle following the `WAIT_HIGH`→`HIGH` edge.
  - `o_btn_release` = 1 for exactly the one cycle following the `WAIT_LOW`→`IDLE_LOW` edge.
- Glitch rejection: any excursion of `sync` shorter than COUNT_MAX+1 consecutive cycles is absorbed. The channel returns to its previous stable state with no output activity.
- A button held indefinitely produces exactly one pulse, with no auto-repeat.
- Simultaneous activity on several channels is handled in parallel. Equal stimulus produces same-cycle pulses on every channel involved.

## Timing
- Reset values:
  - synchronizer flops = 0, counters = 0, FSM = `IDLE_LOW`.
  - `o_btn_level` = 0, `o_btn_pulse` = 0, `o_btn_release` = 0.
  - All outputs are 0 asynchronously while `i_reset` is high.
- Press latency: numbering the first edge that samples the new stable pin level as edge 1, `o_btn_pulse` and `o_btn_level` rise after edge COUNT_MAX+3. Release latency is identical.
- Reset mid-operation discards any partial count. After reset deasserts, a pin already high is treated as a new press and yields one pulse after the full latency.
- No input is sampled while `i_reset` is high.

## Test plan
All scenarios use COUNT_MAX=4, NB_CNT=3, NB_BTN=3, so press/release latency is 7 edges.
- Reset held 5 cycles with `i_btn`=3'b111 → all outputs 0 during reset. After release: one pulse per channel at edge 7, then `o_btn_level`=3'b111.
- `i_btn[0]` pulled high and held 20 cycles, then low → `o_btn_pulse[0]` high exactly 1 cycle at edge 7 and `o_btn_level[0]`=1 from edge 7. `o_btn_release[0]` high exactly 1 cycle at edge 7 after the fall; channels 1 and 2 stay 0.
- `i_btn[1]` toggled every 2 cycles for 12 cycles, then held high → no pulse during the toggling. Exactly one `o_btn_pulse[1]` at edge 7 of the stable high.
- `i_btn[2]` high for 4 cycles (glitch), then low → `o_btn_level[2]`, `o_btn_pulse[2]` and `o_btn_release[2]` remain 0 throughout.
- `i_btn[0]` high; `i_reset` pulsed asynchronously mid-cycle after 4 sampled cycles → outputs stay 0. After reset deasserts, exactly one pulse at edge 7; held 100 cycles → no further pulses.
- All three inputs rise in the same cycle → `o_btn_pulse`=3'b111 for one cycle at edge 7, then 3'b000.
